jtframe_lfbuf_mem: RTL and testbench

JTFRAME_LFBUF_MEM -- requirements
Module: jtframe_lfbuf_mem

---
 rtl/jtframe_lfbuf_dpram.sv | 50 +++++
 rtl/jtframe_lfbuf_mem.sv | 78 +++++++
 tb/tb_jtframe_lfbuf_mem.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/jtframe_lfbuf_dpram.sv
// ============================================================================
// Module   : jtframe_lfbuf_dpram
// Purpose  : Generic true dual-port synchronous RAM, read-first, port B wins
//            on a same-address write collision.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtframe_lfbuf_dpram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          we_a,
  output logic [DW-1:0] q_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  input  logic          we_b,
  output logic [DW-1:0] q_b
);

  localparam int c_DEPTH = 2**AW;

  logic [DW-1:0] r_mem [0:c_DEPTH-1] = '{default: '0};

  // Array carries no reset so it maps onto block RAM; rst only blocks writes.
  // Port B is written last so it overrides port A on a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we_a) r_mem[addr_a] <= data_a;
      if (we_b) r_mem[addr_b] <= data_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= r_mem[addr_a];
      q_b <= r_mem[addr_b];
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtframe_lfbuf_mem.sv
// ============================================================================
// Module   : jtframe_lfbuf_mem
// Purpose  : Line/frame buffer memories: double line buffer with dump and
//            clear-after-read, plus the screen buffer fed from external RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtframe_lfbuf_mem #(
  parameter int          DW      = 16,
  parameter int          HW      = 9,
  parameter logic [15:0] CLR_VAL = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line,
  input  logic [HW-1:0] ln_addr,
  input  logic [DW-1:0] ln_data,
  input  logic          ln_we,
  input  logic [HW-1:0] fb_addr,
  input  logic          fb_clr,
  output logic [15:0]   fb_din,
  input  logic [15:0]   fb_dout,
  input  logic [HW-1:0] rd_addr,
  input  logic          scr_we,
  input  logic [HW-1:0] hdump,
  output logic [DW-1:0] ln_pxl
);

  logic [HW:0]   w_dump_addr;
  logic [HW:0]   w_core_addr;
  logic [15:0]   w_core_data;
  logic [15:0]   w_unused_core_q;
  logic [15:0]   w_unused_scr_qa;
  logic [15:0]   w_scr_q;

  // Clearing targets the half the core is not writing.
  assign w_dump_addr = {line ^ fb_clr, fb_addr};
  assign w_core_addr = {line, ln_addr};
  assign w_core_data = 16'(ln_data);

  jtframe_lfbuf_dpram #(
    .DW ( 16   ),
    .AW ( HW+1 )
  ) u_linebuf (
    .clk    ( clk             ),
    .rst    ( rst             ),
    .addr_a ( w_dump_addr     ),
    .data_a ( CLR_VAL         ),
    .we_a   ( fb_clr          ),
    .q_a    ( fb_din          ),
    .addr_b ( w_core_addr     ),
    .data_b ( w_core_data     ),
    .we_b   ( ln_we           ),
    .q_b    ( w_unused_core_q )
  );

  jtframe_lfbuf_dpram #(
    .DW ( 16 ),
    .AW ( HW )
  ) u_scrbuf (
    .clk    ( clk             ),
    .rst    ( rst             ),
    .addr_a ( rd_addr         ),
    .data_a ( fb_dout         ),
    .we_a   ( scr_we          ),
    .q_a    ( w_unused_scr_qa ),
    .addr_b ( hdump           ),
    .data_b ( 16'h0000        ),
    .we_b   ( 1'b0            ),
    .q_b    ( w_scr_q         )
  );

  assign ln_pxl = w_scr_q[DW-1:0];

endmodule

`default_nettype wire

// File: tb/tb_jtframe_lfbuf_mem.sv
// Directed bench for jtframe_lfbuf_mem: a 16-bit and an 8-bit pixel instance.
`default_nettype none

module tb_jtframe_lfbuf_mem;

  localparam int HW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          line;
  logic [HW-1:0] ln_addr;
  logic [15:0]   ln_data;
  logic          ln_we;
  logic [HW-1:0] fb_addr;
  logic          fb_clr;
  logic [15:0]   fb_din;
  logic [15:0]   fb_din8;
  logic [15:0]   fb_dout;
  logic [HW-1:0] rd_addr;
  logic          scr_we;
  logic [HW-1:0] hdump;
  logic [15:0]   ln_pxl;
  logic [7:0]    ln_pxl8;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  jtframe_lfbuf_mem #(.DW(16), .HW(HW), .CLR_VAL(16'h0000)) dut (
    .clk(clk), .rst(rst), .line(line), .ln_addr(ln_addr), .ln_data(ln_data),
    .ln_we(ln_we), .fb_addr(fb_addr), .fb_clr(fb_clr), .fb_din(fb_din),
    .fb_dout(fb_dout), .rd_addr(rd_addr), .scr_we(scr_we), .hdump(hdump),
    .ln_pxl(ln_pxl)
  );

  jtframe_lfbuf_mem #(.DW(8), .HW(HW), .CLR_VAL(16'h0000)) dut8 (
    .clk(clk), .rst(rst), .line(line), .ln_addr(ln_addr), .ln_data(ln_data[7:0]),
    .ln_we(ln_we), .fb_addr(fb_addr), .fb_clr(fb_clr), .fb_din(fb_din8),
    .fb_dout(fb_dout), .rd_addr(rd_addr), .scr_we(scr_we), .hdump(hdump),
    .ln_pxl(ln_pxl8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; line = 1'b0; ln_addr = '0; ln_data = '0; ln_we = 1'b0;
    fb_addr = '0; fb_clr = 1'b0; fb_dout = '0; rd_addr = '0; scr_we = 1'b0;
    hdump = '0;
    step(); step();
    check("reset_fb_din", fb_din, 16'h0000);
    check("reset_ln_pxl", ln_pxl, 16'h0000);
    check("reset_ln_pxl8", {8'h00, ln_pxl8}, 16'h0000);
    rst = 1'b0;

    // core write into half 0, then dump it back
    line = 1'b0; ln_we = 1'b1; ln_addr = 9'd5; ln_data = 16'h1234;
    step();
    ln_we = 1'b0; ln_data = 16'hFFFF; fb_addr = 9'd5;
    step();
    check("dump_h0_5", fb_din, 16'h1234);
    line = 1'b1;
    step();
    check("dump_h1_5_empty", fb_din, 16'h0000);

    // clear-after-read: line=1, fb_clr=1 addresses half 0
    fb_clr = 1'b1;
    step();
    check("clr_read_old", fb_din, 16'h1234);
    fb_clr = 1'b0; line = 1'b0;
    step();
    check("clr_result", fb_din, 16'h0000);

    // screen path
    scr_we = 1'b1; rd_addr = 9'd3; fb_dout = 16'hABCD;
    step();
    scr_we = 1'b0; fb_dout = 16'h0000; hdump = 9'd3;
    step();
    check("scr_pxl16", ln_pxl, 16'hABCD);
    check("scr_pxl8", {8'h00, ln_pxl8}, 16'h00CD);

    // read-first on the screen buffer
    scr_we = 1'b1; rd_addr = 9'd7; fb_dout = 16'h1111; hdump = 9'd0;
    step();
    fb_dout = 16'h5555; hdump = 9'd7;
    step();
    check("scr_read_first", ln_pxl, 16'h1111);
    scr_we = 1'b0;
    step();
    check("scr_new_data", ln_pxl, 16'h5555);

    // read-first across ports of the line buffer
    line = 1'b0; ln_we = 1'b1; ln_addr = 9'd6; ln_data = 16'hAAAA; fb_addr = 9'd6;
    step();
    check("lb_cross_read_first", fb_din, 16'h0000);
    ln_we = 1'b0;
    step();
    check("lb_cross_new", fb_din, 16'hAAAA);

    // core write and clear in the same cycle
    line = 1'b0; ln_we = 1'b1; ln_addr = 9'd9; ln_data = 16'h00FF;
    fb_clr = 1'b1; fb_addr = 9'd9;
    step();
    ln_we = 1'b0; fb_clr = 1'b0;
    step();
    check("collision_core_kept", fb_din, 16'h00FF);

    // reset keeps contents and blocks writes
    scr_we = 1'b1; rd_addr = 9'd2; fb_dout = 16'h0F0F;
    step();
    scr_we = 1'b0; hdump = 9'd2;
    step();
    check("pre_rst_pxl", ln_pxl, 16'h0F0F);
    rst = 1'b1; scr_we = 1'b1; fb_dout = 16'hDEAD;
    line = 1'b0; fb_addr = 9'd9; ln_we = 1'b1; ln_addr = 9'd9; ln_data = 16'h7777;
    step();
    check("rst_pxl_c1", ln_pxl, 16'h0000);
    check("rst_fb_din_c1", fb_din, 16'h0000);
    step();
    check("rst_pxl_c2", ln_pxl, 16'h0000);
    rst = 1'b0; scr_we = 1'b0; ln_we = 1'b0;
    step();
    check("post_rst_pxl", ln_pxl, 16'h0F0F);
    check("post_rst_pxl8", {8'h00, ln_pxl8}, 16'h000F);
    check("post_rst_fb_din", fb_din, 16'h00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
